// File: rtl/pong_physics.sv
// Pong motion engine: two clamped paddles, a bouncing ball with paddle/wall
// collision, miss detection and a short hold in MISS before the ball is re-served.

module pong_paddle #(
    parameter int SCREEN_H    = 480,
    parameter int PADDLE_H    = 64,
    parameter int PADDLE_STEP = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       en_i,
    input  logic       up_i,
    input  logic       down_i,
    output logic [9:0] y_o
);
    localparam logic [9:0]  Y_RST  = 10'((SCREEN_H - PADDLE_H) / 2);
    localparam logic [9:0]  Y_MAX  = 10'(SCREEN_H - PADDLE_H);
    localparam logic [9:0]  STEP10 = 10'(PADDLE_STEP);
    localparam logic [10:0] STEP11 = 11'(PADDLE_STEP);
    localparam logic [10:0] YMAX11 = 11'(SCREEN_H - PADDLE_H);

    logic [9:0]  y_q, y_d;
    logic [10:0] y_dn;

    assign y_dn = {1'b0, y_q} + STEP11;

    always_comb begin
        y_d = y_q;
        if (en_i && up_i && !down_i)
            y_d = (y_q < STEP10) ? 10'd0 : y_q - STEP10;
        else if (en_i && down_i && !up_i)
            y_d = (y_dn > YMAX11) ? Y_MAX : y_dn[9:0];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) y_q <= Y_RST;
        else       y_q <= y_d;
    end

    assign y_o = y_q;
endmodule

module pong_physics #(
    parameter int SCREEN_W    = 640,
    parameter int SCREEN_H    = 480,
    parameter int BALL_SIZE   = 8,
    parameter int PADDLE_W    = 8,
    parameter int PADDLE_H    = 64,
    parameter int PADDLE1_X   = 16,
    parameter int PADDLE2_X   = 616,
    parameter int PADDLE_STEP = 4,
    parameter int SPEED0      = 2,
    parameter int SPEED_MAX   = 6,
    parameter int MISS_HOLD   = 2
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       tick_i,
    input  logic       stop_i,
    input  logic       up1_i,
    input  logic       down1_i,
    input  logic       up2_i,
    input  logic       down2_i,
    input  logic       speed_up_i,
    output logic [9:0] ball_x_o,
    output logic [9:0] ball_y_o,
    output logic [9:0] paddle1_y_o,
    output logic [9:0] paddle2_y_o,
    output logic       miss1_o,
    output logic       miss2_o
);
    localparam int SPW = $clog2(SPEED_MAX + 1);
    localparam int HW  = $clog2(MISS_HOLD + 1);

    localparam logic [9:0]         CX    = 10'((SCREEN_W - BALL_SIZE) / 2);
    localparam logic [9:0]         CY    = 10'((SCREEN_H - BALL_SIZE) / 2);
    localparam logic [9:0]         LX10  = 10'(PADDLE1_X + PADDLE_W);
    localparam logic [9:0]         RX10  = 10'(PADDLE2_X - BALL_SIZE);
    localparam logic [9:0]         YB10  = 10'(SCREEN_H - BALL_SIZE);
    localparam logic signed [10:0] LFACE = 11'(PADDLE1_X + PADDLE_W);
    localparam logic signed [10:0] RFACE = 11'(PADDLE2_X - BALL_SIZE);
    localparam logic signed [10:0] XMAX  = 11'(SCREEN_W - BALL_SIZE);
    localparam logic signed [10:0] YMAX  = 11'(SCREEN_H - BALL_SIZE);
    localparam logic [10:0]        BS11  = 11'(BALL_SIZE);
    localparam logic [10:0]        PH11  = 11'(PADDLE_H);

    typedef enum logic [1:0] {S_IDLE, S_PLAY, S_MISS} state_t;

    state_t          state_q, state_d;
    logic [9:0]      bx_q, bx_d, by_q, by_d;
    logic            dxn_q, dxn_d, dyn_q, dyn_d;   // 1 = moving left / up
    logic [SPW-1:0]  spd_q, spd_d;
    logic [HW-1:0]   hold_q, hold_d;
    logic            miss1_q, miss1_d, miss2_q, miss2_d;

    logic            move, pad_en;
    logic [1:0]      pad_up, pad_dn;
    logic [1:0][9:0] pad_y;

    assign move   = tick_i && !stop_i;
    assign pad_en = move && (state_q != S_IDLE);
    assign pad_up = {up2_i, up1_i};
    assign pad_dn = {down2_i, down1_i};

    for (genvar g = 0; g < 2; g++) begin : g_pad
        pong_paddle #(
            .SCREEN_H    (SCREEN_H),
            .PADDLE_H    (PADDLE_H),
            .PADDLE_STEP (PADDLE_STEP)
        ) u_pad (
            .clk_i  (clk_i),
            .rst_i  (rst_i),
            .en_i   (pad_en),
            .up_i   (pad_up[g]),
            .down_i (pad_dn[g]),
            .y_o    (pad_y[g])
        );
    end

    // Candidate position in signed 11 bits so a step past 0 goes negative, not wraps.
    logic signed [10:0] sx, sy, spd_s, nx, ny;
    logic [10:0]        by11, p1_11, p2_11;
    logic               ov1, ov2, hit1, hit2, m1, m2;

    assign sx    = $signed({1'b0, bx_q});
    assign sy    = $signed({1'b0, by_q});
    assign spd_s = $signed(11'(spd_q));
    assign nx    = dxn_q ? sx - spd_s : sx + spd_s;
    assign ny    = dyn_q ? sy - spd_s : sy + spd_s;

    assign by11  = {1'b0, by_q};
    assign p1_11 = {1'b0, pad_y[0]};
    assign p2_11 = {1'b0, pad_y[1]};
    assign ov1   = (by11 + BS11 > p1_11) && (by11 < p1_11 + PH11);
    assign ov2   = (by11 + BS11 > p2_11) && (by11 < p2_11 + PH11);
    assign hit1  = dxn_q && (sx >= LFACE) && (nx <= LFACE) && ov1;
    assign hit2  = !dxn_q && (sx <= RFACE) && (nx >= RFACE) && ov2;
    assign m1    = !hit1 && !hit2 && (nx <= 11'sd0);
    assign m2    = !hit1 && !hit2 && !m1 && (nx >= XMAX);

    always_comb begin
        state_d = state_q;
        bx_d    = bx_q;
        by_d    = by_q;
        dxn_d   = dxn_q;
        dyn_d   = dyn_q;
        spd_d   = spd_q;
        hold_d  = hold_q;
        miss1_d = 1'b0;
        miss2_d = 1'b0;

        if (speed_up_i && state_q != S_IDLE && spd_q < SPW'(SPEED_MAX))
            spd_d = spd_q + 1'b1;

        case (state_q)
            S_IDLE: begin
                bx_d = CX;
                by_d = CY;
                if (!stop_i) state_d = S_PLAY;
            end
            S_PLAY: begin
                if (move) begin
                    if (ny <= 11'sd0) begin
                        by_d  = 10'd0;
                        dyn_d = 1'b0;
                    end else if (ny >= YMAX) begin
                        by_d  = YB10;
                        dyn_d = 1'b1;
                    end else begin
                        by_d  = ny[9:0];
                    end

                    if (hit1) begin
                        bx_d  = LX10;
                        dxn_d = 1'b0;
                    end else if (hit2) begin
                        bx_d  = RX10;
                        dxn_d = 1'b1;
                    end else if (m1 || m2) begin
                        // Re-serve toward the player who just scored; vertical direction is untouched.
                        bx_d    = CX;
                        by_d    = CY;
                        dyn_d   = dyn_q;
                        dxn_d   = m2;
                        hold_d  = '0;
                        miss1_d = m1;
                        miss2_d = m2;
                        state_d = S_MISS;
                    end else begin
                        bx_d  = nx[9:0];
                    end
                end
            end
            S_MISS: begin
                bx_d = CX;
                by_d = CY;
                if (tick_i) begin
                    if (hold_q >= HW'(MISS_HOLD) && !stop_i) state_d = S_PLAY;
                    else if (hold_q < HW'(MISS_HOLD))        hold_d  = hold_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            bx_q    <= CX;
            by_q    <= CY;
            dxn_q   <= 1'b0;
            dyn_q   <= 1'b0;
            spd_q   <= SPW'(SPEED0);
            hold_q  <= '0;
            miss1_q <= 1'b0;
            miss2_q <= 1'b0;
        end else begin
            state_q <= state_d;
            bx_q    <= bx_d;
            by_q    <= by_d;
            dxn_q   <= dxn_d;
            dyn_q   <= dyn_d;
            spd_q   <= spd_d;
            hold_q  <= hold_d;
            miss1_q <= miss1_d;
            miss2_q <= miss2_d;
        end
    end

    assign ball_x_o    = bx_q;
    assign ball_y_o    = by_q;
    assign paddle1_y_o = pad_y[0];
    assign paddle2_y_o = pad_y[1];
    assign miss1_o     = miss1_q;
    assign miss2_o     = miss2_q;
endmodule

// File: tb/tb_pong_physics.sv
// Bench for pong_physics: integer-arithmetic game model compared every cycle,
// directed literal checks for reset/freeze/clamp/speed/miss, then random play.

module tb_pong_physics;
    logic       clk = 1'b0;
    logic       rst, tick, stop, up1, down1, up2, down2, speed_up;
    logic [9:0] ball_x, ball_y, paddle1_y, paddle2_y;
    logic       miss1, miss2;

    int checks = 0;
    int errs   = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    pong_physics dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .tick_i      (tick),
        .stop_i      (stop),
        .up1_i       (up1),
        .down1_i     (down1),
        .up2_i       (up2),
        .down2_i     (down2),
        .speed_up_i  (speed_up),
        .ball_x_o    (ball_x),
        .ball_y_o    (ball_y),
        .paddle1_y_o (paddle1_y),
        .paddle2_y_o (paddle2_y),
        .miss1_o     (miss1),
        .miss2_o     (miss2)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: 0=idle 1=play 2=miss; velocities as +1/-1 integers.
    int m_mode, m_bx, m_by, m_dx, m_dy, m_spd, m_hold;
    int m_p[2];
    bit m_m1, m_m2;

    always @(posedge clk) begin : model
        int nbx, nby, ndx, ndy, nspd, nhold, nmode, tx, ty;
        int np[2];
        bit mv, hitl, hitr, nm1, nm2, pu, pd;
        if (rst) begin
            m_mode = 0; m_bx = 316; m_by = 236; m_dx = 1; m_dy = 1;
            m_spd = 2; m_hold = 0; m_p[0] = 208; m_p[1] = 208; m_m1 = 0; m_m2 = 0;
        end else begin
            mv = tick && !stop;
            nbx = m_bx; nby = m_by; ndx = m_dx; ndy = m_dy; nspd = m_spd;
            nhold = m_hold; nmode = m_mode; np = m_p; nm1 = 0; nm2 = 0;
            if (m_mode != 0 && speed_up && m_spd < 6) nspd = m_spd + 1;
            if (m_mode != 0 && mv) begin
                for (int i = 0; i < 2; i++) begin
                    pu = (i == 0) ? up1 : up2;
                    pd = (i == 0) ? down1 : down2;
                    if (pu && !pd)      np[i] = (m_p[i] - 4 < 0) ? 0 : m_p[i] - 4;
                    else if (pd && !pu) np[i] = (m_p[i] + 4 > 416) ? 416 : m_p[i] + 4;
                end
            end
            case (m_mode)
                0: begin
                    nbx = 316; nby = 236;
                    if (!stop) nmode = 1;
                end
                1: if (mv) begin
                    tx = m_bx + m_dx * m_spd;
                    ty = m_by + m_dy * m_spd;
                    if (ty <= 0)        begin nby = 0;   ndy = 1;  end
                    else if (ty >= 472) begin nby = 472; ndy = -1; end
                    else                nby = ty;
                    hitl = m_dx < 0 && m_bx >= 24 && tx <= 24 && m_by + 8 > m_p[0] && m_by < m_p[0] + 64;
                    hitr = m_dx > 0 && m_bx <= 608 && tx >= 608 && m_by + 8 > m_p[1] && m_by < m_p[1] + 64;
                    if (hitl)      begin nbx = 24;  ndx = 1;  end
                    else if (hitr) begin nbx = 608; ndx = -1; end
                    else if (tx <= 0 || tx >= 632) begin
                        nm1 = (tx <= 0); nm2 = !nm1;
                        nbx = 316; nby = 236; ndy = m_dy; ndx = nm1 ? 1 : -1;
                        nhold = 0; nmode = 2;
                    end else nbx = tx;
                end
                default: begin
                    nbx = 316; nby = 236;
                    if (tick) begin
                        if (m_hold >= 2 && !stop) nmode = 1;
                        else if (m_hold < 2)      nhold = m_hold + 1;
                    end
                end
            endcase
            m_bx = nbx; m_by = nby; m_dx = ndx; m_dy = ndy; m_spd = nspd;
            m_hold = nhold; m_mode = nmode; m_p = np; m_m1 = nm1; m_m2 = nm2;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("ball_x", ball_x, m_bx);
            chk("ball_y", ball_y, m_by);
            chk("paddle1_y", paddle1_y, m_p[0]);
            chk("paddle2_y", paddle2_y, m_p[1]);
            chk("miss1", miss1, m_m1);
            chk("miss2", miss2, m_m2);
        end
    end

    task automatic tick1();
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
    endtask

    initial begin
        bit seen;
        rst = 1; stop = 1; tick = 0; up1 = 0; down1 = 0; up2 = 0; down2 = 0; speed_up = 0;
        repeat (2) @(negedge clk);
        rst = 0; chk_en = 1;

        // Reset values and IDLE hold while stopped
        chk("rst_ball_x", ball_x, 316);
        chk("rst_ball_y", ball_y, 236);
        chk("rst_p1", paddle1_y, 208);
        chk("rst_p2", paddle2_y, 208);
        chk("rst_miss", {miss1, miss2}, 0);
        repeat (3) tick1();
        chk("idle_ball_x", ball_x, 316);
        chk("idle_ball_y", ball_y, 236);

        // Enter PLAY, then freeze with up1 held
        stop = 0; @(negedge clk);
        stop = 1; up1 = 1;
        repeat (10) tick1();
        chk("freeze_p1", paddle1_y, 208);
        chk("freeze_ball_x", ball_x, 316);
        stop = 0; up1 = 0;
        tick1();
        chk("first_ball_x", ball_x, 318);
        chk("first_ball_y", ball_y, 238);

        // Clamp at top, then step down and hold with both pressed
        up1 = 1;
        repeat (60) tick1();
        chk("clamp_p1", paddle1_y, 0);
        up1 = 0; down1 = 1;
        repeat (5) tick1();
        chk("down_p1", paddle1_y, 20);
        up1 = 1;
        repeat (3) tick1();
        chk("both_p1", paddle1_y, 20);
        up1 = 0; down1 = 0;

        // Speed ramp and saturation
        rst = 1; @(negedge clk); rst = 0; @(negedge clk);
        repeat (6) begin speed_up = 1; @(negedge clk); speed_up = 0; end
        tick1();
        chk("spd6_ball_x", ball_x, 322);
        chk("spd6_ball_y", ball_y, 242);
        repeat (2) begin speed_up = 1; @(negedge clk); speed_up = 0; end
        tick1();
        chk("spdsat_ball_x", ball_x, 328);

        // Reset restores speed; speed_up in IDLE ignored
        rst = 1; stop = 1; @(negedge clk); rst = 0;
        repeat (3) begin speed_up = 1; @(negedge clk); speed_up = 0; end
        stop = 0; @(negedge clk);
        tick1();
        chk("spd2_ball_x", ball_x, 318);

        // Right paddle parked at top: ball must pass it and miss2
        up2 = 1; tick = 1; seen = 0;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(negedge clk);
            seen = miss2;
        end
        tick = 0; up2 = 0;
        chk("miss2_seen", seen, 1);
        chk("miss_ball_x", ball_x, 316);
        chk("miss_ball_y", ball_y, 236);
        chk("miss_no_m1", miss1, 0);
        @(negedge clk);
        chk("miss2_pulse", miss2, 0);
        repeat (3) tick1();
        chk("hold_ball_x", ball_x, 316);
        tick1();
        chk("serve_ball_x", ball_x, 314);
        chk("serve_ball_y", ball_y, 234);

        // Random play
        for (int i = 0; i < 6000; i++) begin
            tick     = ($urandom_range(0, 3) == 0);
            stop     = ($urandom_range(0, 19) == 0);
            speed_up = ($urandom_range(0, 199) == 0);
            rst      = ($urandom_range(0, 1999) == 0);
            if ($urandom_range(0, 15) == 0) up1   = $urandom_range(0, 1);
            if ($urandom_range(0, 15) == 0) down1 = $urandom_range(0, 1);
            if ($urandom_range(0, 15) == 0) up2   = $urandom_range(0, 1);
            if ($urandom_range(0, 15) == 0) down2 = $urandom_range(0, 1);
            @(negedge clk);
        end
        rst = 0; tick = 0;
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errs);
        $finish;
    end
endmodule
